nfc_cmd_scheduler: RTL and testbench

NFC_CMD_SCHEDULER -- requirements
Module: nfc_cmd_scheduler

---
 rtl/nfc_cmd_scheduler.sv | 122 ++++++++++++
 tb/tb_nfc_cmd_scheduler.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/nfc_cmd_scheduler.sv
// Two-requester round-robin command scheduler for a NAND flash controller.
// Issues one command at a time, waits for completion or timer abort, and reports status.
module nfc_cmd_scheduler #(
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  cmd0,
    input  logic [2:0]  cmd1,
    input  logic [15:0] rwa0,
    input  logic [15:0] rwa1,
    output logic        grant0,
    output logic        grant1,
    output logic        done0,
    output logic        done1,
    output logic        fail,
    output logic        timeout,
    output logic        busy,
    output logic        nfc_start,
    output logic [2:0]  nfc_cmd,
    output logic [15:0] RWA,
    input  logic        nfc_done,
    input  logic        nfc_fail
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT     = 3'd2,
        REJECT   = 3'd3,
        COMPLETE = 3'd4
    } state_t;

    localparam logic [16:0] CNT_LAST = 17'(TIMEOUT - 1);
    localparam logic [2:0]  CMD_MAX  = 3'd2;

    state_t      state, state_nxt;
    logic        ptr;
    logic        owner;
    logic [16:0] cnt;
    logic        sel;
    logic [2:0]  sel_cmd;
    logic        any_req;
    logic        cnt_hit;

    // Requester 1 wins when it is alone or holds the round-robin token.
    assign any_req = req0 | req1;
    assign sel     = req1 & (~req0 | ptr);
    assign sel_cmd = sel ? cmd1 : cmd0;
    assign cnt_hit = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_req) state_nxt = (sel_cmd <= CMD_MAX) ? ISSUE : REJECT;
            ISSUE:    state_nxt = WAIT;
            WAIT:     if (nfc_done || cnt_hit) state_nxt = COMPLETE;
            REJECT:   state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            cnt     <= '0;
            nfc_cmd <= '0;
            RWA     <= '0;
            fail    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= sel;
                        nfc_cmd <= sel_cmd;
                        RWA     <= sel ? rwa1 : rwa0;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 17'd1;
                    // Controller completion takes precedence over a same-cycle timer expiry.
                    if (nfc_done) begin
                        fail    <= nfc_fail;
                        timeout <= 1'b0;
                    end else if (cnt_hit) begin
                        fail    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                REJECT: begin
                    fail    <= 1'b1;
                    timeout <= 1'b0;
                end
                COMPLETE: begin
                    ptr     <= ~owner;
                    fail    <= 1'b0;
                    timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign nfc_start = (state == ISSUE);
    assign grant0    = ((state == ISSUE) || (state == REJECT)) && !owner;
    assign grant1    = ((state == ISSUE) || (state == REJECT)) &&  owner;
    assign done0     = (state == COMPLETE) && !owner;
    assign done1     = (state == COMPLETE) &&  owner;

endmodule

// File: tb/tb_nfc_cmd_scheduler.sv
// Directed bench for nfc_cmd_scheduler: cycle vector table plus hand-written
// sequences for timeout, collision, contention and mid-command reset.
module tb_nfc_cmd_scheduler;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req0, req1;
    logic [2:0]  cmd0, cmd1;
    logic [15:0] rwa0, rwa1;
    logic        grant0, grant1, done0, done1, fail, timeout, busy, nfc_start;
    logic [2:0]  nfc_cmd;
    logic [15:0] RWA;
    logic        nfc_done, nfc_fail;

    int total = 0;
    int bad   = 0;

    nfc_cmd_scheduler #(.TIMEOUT(8)) dut (
        .clk(clk), .Reset(Reset),
        .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1), .rwa0(rwa0), .rwa1(rwa1),
        .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
        .fail(fail), .timeout(timeout), .busy(busy), .nfc_start(nfc_start),
        .nfc_cmd(nfc_cmd), .RWA(RWA), .nfc_done(nfc_done), .nfc_fail(nfc_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1;
        logic [2:0]  c0, c1;
        logic [15:0] a0, a1;
        logic        nd, nf;
        logic [7:0]  ef;   // {grant0,grant1,done0,done1,fail,timeout,busy,nfc_start}
        logic [2:0]  ec;
        logic [15:0] ea;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r0, input logic r1, input logic [2:0] c0,
                                input logic [2:0] c1, input logic [15:0] a0, input logic [15:0] a1,
                                input logic nd, input logic nf, input logic [7:0] ef,
                                input logic [2:0] ec, input logic [15:0] ea);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1; v.a0 = a0; v.a1 = a1;
        v.nd = nd; v.nf = nf; v.ef = ef; v.ec = ec; v.ea = ea;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] outs();
        return {grant0, grant1, done0, done1, fail, timeout, busy, nfc_start, nfc_cmd, RWA};
    endfunction

    initial begin
        logic [26:0] got, exp;
        int n;
        logic seen;

        Reset = 1'b1; req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; rwa0 = 0; rwa1 = 0;
        nfc_done = 0; nfc_fail = 0;

        // Erase, done after 5 WAIT cycles; stray controller strobes outside WAIT.
        tbl.push_back(mk(1,0,0,0,16'h0010,0,0,0,8'b1000_0011,3'd0,16'h0010));
        tbl.push_back(mk(1,0,0,0,16'h0010,0,0,0,8'b0000_0010,3'd0,16'h0010));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,0,0,16'h0010,0,0,0,8'b0000_0010,3'd0,16'h0010));
        tbl.push_back(mk(1,0,0,0,16'h0010,0,1,0,8'b0010_0010,3'd0,16'h0010));
        tbl.push_back(mk(0,0,0,0,16'h0010,0,1,1,8'b0000_0000,3'd0,16'h0010));
        tbl.push_back(mk(0,0,0,0,16'h0010,0,1,1,8'b0000_0000,3'd0,16'h0010));
        // Illegal command from requester 1: grant, no start, failing done.
        tbl.push_back(mk(0,1,0,3'd5,0,16'hBEEF,0,0,8'b0100_0010,3'd5,16'hBEEF));
        tbl.push_back(mk(0,1,0,3'd5,0,16'hBEEF,0,0,8'b0001_1010,3'd5,16'hBEEF));
        tbl.push_back(mk(0,0,0,3'd5,0,16'hBEEF,0,0,8'b0000_0000,3'd5,16'hBEEF));
        // Lone requester 1 while token sits with 0; controller reports an error.
        tbl.push_back(mk(0,1,0,3'd1,0,16'h1234,0,0,8'b0100_0011,3'd1,16'h1234));
        tbl.push_back(mk(0,1,0,3'd1,0,16'h1234,0,0,8'b0000_0010,3'd1,16'h1234));
        tbl.push_back(mk(0,1,0,3'd1,0,16'h1234,1,1,8'b0001_1010,3'd1,16'h1234));
        tbl.push_back(mk(0,0,0,3'd1,0,16'h1234,0,0,8'b0000_0000,3'd1,16'h1234));

        tick(); tick();
        chk("reset_outputs", 32'(outs()), 32'd0);
        Reset = 1'b0;

        foreach (tbl[i]) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1; cmd0 = tbl[i].c0; cmd1 = tbl[i].c1;
            rwa0 = tbl[i].a0; rwa1 = tbl[i].a1; nfc_done = tbl[i].nd; nfc_fail = tbl[i].nf;
            tick();
            got = outs();
            exp = {tbl[i].ef, tbl[i].ec, tbl[i].ea};
            // Status bits are only meaningful alongside a done pulse.
            if (!(tbl[i].ef[5] | tbl[i].ef[4])) begin
                got[22:21] = 2'b00;
                exp[22:21] = 2'b00;
            end
            chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
        end
        nfc_done = 0; nfc_fail = 0;

        // Timer abort: done exactly 8 cycles after entering WAIT.
        req0 = 1; cmd0 = 3'd2; rwa0 = 16'h00AA;
        tick();
        chk("to_issue", {nfc_start, grant0, nfc_cmd, RWA}, {1'b1, 1'b1, 3'd2, 16'h00AA});
        tick();
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            tick(); n++;
            seen = done0;
        end
        chk("to_cycles", n, 8);
        chk("to_status", {done0, fail, timeout}, 3'b111);
        req0 = 0;
        tick();
        chk("to_idle", busy, 0);

        // nfc_done coinciding with the last timer cycle completes normally.
        req1 = 1; cmd1 = 3'd1; rwa1 = 16'h0055;
        tick();
        chk("col_grant", {grant1, nfc_start}, 2'b11);
        tick();
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            seen = seen | done1;
        end
        chk("col_no_early_done", seen, 0);
        nfc_done = 1; nfc_fail = 0;
        tick();
        chk("col_status", {done1, fail, timeout}, 3'b100);
        nfc_done = 0; req1 = 0;
        tick();

        // Contention from reset: 0, then 1, then 0 again.
        Reset = 1; tick(); Reset = 0;
        req0 = 1; req1 = 1; cmd0 = 3'd1; cmd1 = 3'd2; rwa0 = 16'h0100; rwa1 = 16'h0200;
        tick();
        chk("rr_first", {grant0, grant1, nfc_cmd, RWA}, {2'b10, 3'd1, 16'h0100});
        tick(); nfc_done = 1; tick();
        chk("rr_done0", {done0, done1}, 2'b10);
        nfc_done = 0; tick();
        tick();
        chk("rr_second", {grant0, grant1, nfc_cmd, RWA}, {2'b01, 3'd2, 16'h0200});
        tick(); nfc_done = 1; tick();
        chk("rr_done1", {done0, done1}, 2'b01);
        nfc_done = 0; tick();
        tick();
        chk("rr_third", {grant0, grant1, nfc_cmd, RWA}, {2'b10, 3'd1, 16'h0100});
        tick(); nfc_done = 1; tick();
        nfc_done = 0; req0 = 0; req1 = 0;
        tick();

        // Reset in WAIT: immediate clear, no done, then normal service favouring 0.
        req0 = 1; cmd0 = 3'd2; rwa0 = 16'h0F0F;
        tick(); tick(); tick();
        chk("rst_busy_before", busy, 1);
        #2 Reset = 1; req0 = 0;
        #1 chk("rst_async_clear", 32'(outs()), 32'd0);
        tick();
        Reset = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | done0 | done1 | busy;
        end
        chk("rst_no_done", seen, 0);
        req0 = 1; req1 = 1; cmd0 = 3'd0; cmd1 = 3'd1; rwa0 = 16'h0042; rwa1 = 16'h0043;
        tick();
        chk("rst_favour0", {grant0, grant1, nfc_start, nfc_cmd, RWA}, {3'b101, 3'd0, 16'h0042});
        tick(); nfc_done = 1; nfc_fail = 0; tick();
        chk("rst_done0", {done0, done1, fail, timeout}, 4'b1000);
        nfc_done = 0; req0 = 0; req1 = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
